mem_stage_sram: RTL and testbench

Memory stage of the MIPS pipeline. Sits directly downstream of the execute stage: it consumes the ALU result as a data address and the forwarded second source operand as store data, and performs loads and stores against an external 16-bit-wide SRAM. Each 32-bit word takes two half-word SRAM accesses with configurable wait states. `ready` freezes the rest of the pipeline while an access is in flight.

---
 rtl/mem_stage_sram.sv | 118 +++++++++++
 tb/tb_mem_stage_sram.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_sram.sv
// MIPS memory stage: 32-bit load/store as two half-word accesses to an external 16-bit SRAM.
// Latency: ready low for 2*WAIT_CYCLES+3 cycles per request; mem_result valid from DONE.
// Backpressure: ready low freezes the pipeline; request inputs must stay stable until DONE.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   mem_r_en, mem_w_en       load / store request (store wins if both set)
//   alu_result, st_val       byte address, store data
//   ready                    high when no access is pending
//   mem_result               word from the most recent completed load
//   sram_addr, sram_dq_out, sram_dq_oe, sram_dq_in, sram_we_n, sram_oe_n   SRAM pins
module mem_stage_sram #(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_BASE   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] alu_result,
  input  logic [31:0] st_val,
  output logic        ready,
  output logic [31:0] mem_result,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n,
  output logic        sram_oe_n
);

  localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [15:0]   lo_q;
  logic [31:0]   phys;
  logic          req;
  logic          last;
  logic          unused_addr_bits;

  assign phys = alu_result - 32'(ADDR_BASE);
  // Byte-lane bits and addresses beyond the SRAM window are deliberately dropped.
  assign unused_addr_bits = ^{phys[31:19], phys[1:0]};
  assign req  = mem_r_en | mem_w_en;
  assign last = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      lo_q       <= '0;
      mem_result <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      // Read data is sampled at the end of each phase, after the wait states.
      if (state == LO && last && !mem_w_en)
        lo_q <= sram_dq_in;
      if (state == HI && last && !mem_w_en)
        mem_result <= {sram_dq_in, lo_q};
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    ready       = 1'b0;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;

    // SRAM strobes and address during the two half-word phases.
    if (state == LO || state == HI) begin
      sram_addr = {phys[18:2], (state == HI)};
      if (mem_w_en) begin
        sram_we_n   = 1'b0;
        sram_dq_oe  = 1'b1;
        sram_dq_out = (state == HI) ? st_val[31:16] : st_val[15:0];
      end else begin
        sram_oe_n = 1'b0;
      end
    end

    case (state)
      IDLE: begin
        ready = !req;
        if (req) begin
          state_nxt = LO;
          cnt_nxt   = '0;
        end
      end
      LO: begin
        if (last) begin
          state_nxt = HI;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      HI: begin
        if (last) state_nxt = DONE;
        else      cnt_nxt   = cnt + CW'(1);
      end
      DONE: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_stage_sram.sv
module tb_mem_stage_sram;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_r_en = 1'b0, mem_w_en = 1'b0;
  logic [31:0] alu_result = '0, st_val = '0;
  logic        ready;
  logic [31:0] mem_result;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n, sram_oe_n;

  // Second instance built with zero wait states (read-only use).
  logic        r0_en = 1'b0, w0_en = 1'b0;
  logic [31:0] alu0 = '0, st0 = '0;
  logic        ready0;
  logic [31:0] res0;
  logic [17:0] addr0;
  logic [15:0] dqo0, dqi0;
  logic        dqoe0, wen0, oen0;

  bit [15:0] mem1 [0:262143];
  bit [15:0] mem0 [0:262143];

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int lat, nw, done_cyc, prev_done;
  bit saw_we, saw_oe, oe_bad;
  logic [17:0] fw_addr, lw_addr;
  logic [15:0] fw_dat, lw_dat;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_stage_sram #(.WAIT_CYCLES(1), .ADDR_BASE(1024)) dut (
    .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .alu_result(alu_result), .st_val(st_val), .ready(ready), .mem_result(mem_result),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n));

  mem_stage_sram #(.WAIT_CYCLES(0), .ADDR_BASE(1024)) dut0 (
    .clk(clk), .rst(rst), .mem_r_en(r0_en), .mem_w_en(w0_en),
    .alu_result(alu0), .st_val(st0), .ready(ready0), .mem_result(res0),
    .sram_addr(addr0), .sram_dq_out(dqo0), .sram_dq_oe(dqoe0),
    .sram_dq_in(dqi0), .sram_we_n(wen0), .sram_oe_n(oen0));

  // Asynchronous SRAM models: write committed at the clock edge while strobed.
  always @(posedge clk)
    if (!sram_we_n && sram_dq_oe) mem1[sram_addr] <= sram_dq_out;
  assign sram_dq_in = sram_oe_n ? 16'h0 : mem1[sram_addr];
  assign dqi0       = oen0 ? 16'h0 : mem0[addr0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one request in the next IDLE cycle and follow it to DONE.
  task automatic txn(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_r_en = rd; mem_w_en = wr; alu_result = a; st_val = d;
    lat = 0; nw = 0; saw_we = 0; saw_oe = 0; oe_bad = 0;
    #1;
    while (!ready && lat < 100) begin
      if (!sram_we_n) begin
        if (!sram_dq_oe) oe_bad = 1;
        if (nw == 0) begin fw_addr = sram_addr; fw_dat = sram_dq_out; end
        lw_addr = sram_addr; lw_dat = sram_dq_out;
        nw++; saw_we = 1;
      end
      if (!sram_oe_n) saw_oe = 1;
      lat++;
      @(negedge clk); #1;
    end
    done_cyc = cyc;
  endtask

  task automatic verify(input string tag, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] er);
    logic [31:0] phys;
    logic [17:0] base;
    phys = a - 32'd1024;
    base = {phys[18:2], 1'b0};
    chk({tag, "_ready_low_cycles"}, 32'(lat), 32'd5);
    if (wr) begin
      chk({tag, "_lo_addr"}, 32'(fw_addr), 32'(base));
      chk({tag, "_lo_data"}, 32'(fw_dat), 32'(d[15:0]));
      chk({tag, "_hi_addr"}, 32'(lw_addr), 32'(base | 18'd1));
      chk({tag, "_hi_data"}, 32'(lw_dat), 32'(d[31:16]));
      chk({tag, "_write_cycles"}, 32'(nw), 32'd4);
      chk({tag, "_oe_n_during_write"}, 32'(saw_oe), 32'd0);
      chk({tag, "_dq_oe_with_we"}, 32'(oe_bad), 32'd0);
    end else begin
      chk({tag, "_no_we_on_read"}, 32'(saw_we), 32'd0);
      chk({tag, "_oe_on_read"}, 32'(saw_oe), 32'd1);
    end
    chk({tag, "_mem_result"}, mem_result, er);
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] st;
    logic [31:0] exp_res;
  } vec_t;

  vec_t tbl [9];
  logic [31:0] ref_mem [int];
  logic [31:0] model_res;

  initial begin
    tbl[0] = '{1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 32'd1028, 32'h0,        32'hDEADBEEF};
    tbl[2] = '{1'b1, 1'b0, 32'd1030, 32'h0,        32'hDEADBEEF};
    tbl[3] = '{1'b1, 1'b1, 32'd1028, 32'h12345678, 32'hDEADBEEF};
    tbl[4] = '{1'b1, 1'b0, 32'd1028, 32'h0,        32'h12345678};
    tbl[5] = '{1'b0, 1'b1, 32'd1024, 32'h11112222, 32'h12345678};
    tbl[6] = '{1'b0, 1'b1, 32'd1032, 32'h33334444, 32'h12345678};
    tbl[7] = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'h11112222};
    tbl[8] = '{1'b1, 1'b0, 32'd1032, 32'h0,        32'h33334444};

    // Reset state, sampled while reset is held.
    #12;
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
    chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_dq_out", 32'(sram_dq_out), 32'd0);
    chk("rst_mem_result", mem_result, 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    @(negedge clk); rst = 1'b0;

    // Directed table, issued back to back.
    prev_done = 0;
    for (int i = 0; i < 9; i++) begin
      txn(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].st);
      verify($sformatf("tbl%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].st, tbl[i].exp_res);
      if (i > 0) chk($sformatf("tbl%0d_done_spacing", i), 32'(done_cyc - prev_done), 32'd6);
      prev_done = done_cyc;
    end

    // mem_result holds across idle cycles.
    @(negedge clk); mem_r_en = 0; mem_w_en = 0;
    repeat (3) @(negedge clk);
    #1 chk("idle_ready", 32'(ready), 32'd1);
    chk("idle_hold_result", mem_result, 32'h33334444);

    // Randomized traffic against a word-level reference memory.
    model_res = 32'h33334444;
    for (int i = 0; i < 40; i++) begin
      int idx, off, op;
      logic [31:0] a, d;
      bit rd, wr;
      idx = $urandom_range(23, 16);
      off = $urandom_range(3, 0);
      op  = $urandom_range(2, 0);
      d   = $urandom();
      a   = 32'(1024 + idx * 4 + off);
      rd  = (op != 1);
      wr  = (op != 0);
      if (wr) ref_mem[idx] = d;
      else    model_res = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
      txn(rd, wr, a, d);
      verify($sformatf("rnd%0d", i), wr, a, d, model_res);
    end

    // Reset in the HI phase of a write.
    begin
      bit found;
      found = 0;
      @(negedge clk);
      mem_r_en = 0; mem_w_en = 1; alu_result = 32'd1036; st_val = 32'hCAFEF00D;
      for (int k = 0; k < 20 && !found; k++) begin
        #1;
        if (!sram_we_n && sram_addr[0]) found = 1;
        else @(negedge clk);
      end
      chk("rst_mid_reached_hi", 32'(found), 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_mid_we_n", 32'(sram_we_n), 32'd1);
      chk("rst_mid_dq_oe", 32'(sram_dq_oe), 32'd0);
      chk("rst_mid_addr", 32'(sram_addr), 32'd0);
      chk("rst_mid_mem_result", mem_result, 32'd0);
      chk("rst_mid_ready_req", 32'(ready), 32'd0);
      mem_w_en = 0;
      #1 chk("rst_mid_idle_ready", 32'(ready), 32'd1);
      @(negedge clk); rst = 1'b0;
      txn(1'b1, 1'b0, 32'd1028, 32'h0);
      verify("post_rst_read", 1'b0, 32'd1028, 32'h0, 32'h12345678);
      @(negedge clk); mem_r_en = 0;
    end

    // Zero-wait-state instance.
    mem0[0] = 16'hA5A5;
    mem0[1] = 16'h5A5A;
    chk("w0_result_before", res0, 32'h0);
    begin
      int lat0;
      @(negedge clk);
      r0_en = 1; alu0 = 32'd1024;
      lat0 = 0;
      #1;
      while (!ready0 && lat0 < 100) begin
        lat0++;
        @(negedge clk); #1;
      end
      chk("w0_ready_low_cycles", 32'(lat0), 32'd3);
      chk("w0_mem_result", res0, 32'h5A5AA5A5);
      @(negedge clk); r0_en = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
